// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle ARM datapath: state sequencing, NZCV flags, condition check.
// Optional CMP/TST no-write decode enabled by defining CMP_TST_NOWRITE_EN.
module multicycle_controller #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUCtrl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  State,
  output logic [3:0]  Flags
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_flags;
  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_rd15;
  logic [1:0]  w_alu_dp;
  logic        w_nowrite;
  logic        w_cond_ok;
  logic        w_pcw, w_memw, w_regw, w_irw;
  logic        w_unused;

  assign w_cond   = Instr[31:28];
  assign w_op     = Instr[27:26];
  assign w_funct  = Instr[25:20];
  assign w_rd15   = (Instr[15:12] == 4'hF);
  assign w_unused = ^{Instr[19:16], Instr[11:0]};

  always_comb begin
    w_alu_dp  = 2'b00;
    w_nowrite = 1'b0;
    case (w_funct[4:1])
      4'b0100: w_alu_dp = 2'b00;
      4'b0010: w_alu_dp = 2'b01;
      4'b0000: w_alu_dp = 2'b10;
      4'b1100: w_alu_dp = 2'b11;
`ifdef CMP_TST_NOWRITE_EN
      4'b1010: begin w_alu_dp = 2'b01; w_nowrite = 1'b1; end
      4'b1000: begin w_alu_dp = 2'b10; w_nowrite = 1'b1; end
`endif
      default: w_alu_dp = 2'b00;
    endcase
  end

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = r_flags;
    case (w_cond)
      4'h0:    w_cond_ok = z;
      4'h1:    w_cond_ok = !z;
      4'h2:    w_cond_ok = c;
      4'h3:    w_cond_ok = !c;
      4'h4:    w_cond_ok = n;
      4'h5:    w_cond_ok = !n;
      4'h6:    w_cond_ok = v;
      4'h7:    w_cond_ok = !v;
      4'h8:    w_cond_ok = c & !z;
      4'h9:    w_cond_ok = !c | z;
      4'hA:    w_cond_ok = (n == v);
      4'hB:    w_cond_ok = (n != v);
      4'hC:    w_cond_ok = !z & (n == v);
      4'hD:    w_cond_ok = z | (n != v);
      4'hE:    w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_FETCH;
      r_flags <= FLAGS_RESET;
    end else begin
      r_state <= w_next;
      // N,Z follow every flag-setting op; C,V only for the arithmetic (ADD/SUB) class
      if ((r_state == S_EXECR || r_state == S_EXECI) && w_funct[0]) begin
        r_flags[3:2] <= ALUFlags[3:2];
        if (!w_alu_dp[1]) r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    w_next    = S_FETCH;
    w_pcw     = 1'b0;
    w_memw    = 1'b0;
    w_regw    = 1'b0;
    w_irw     = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUCtrl   = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_irw = 1'b1; w_pcw = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        if (!w_cond_ok)         w_next = S_FETCH;
        else case (w_op)
          2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        w_next = w_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01; w_regw = 1'b1; w_pcw = w_rd15;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; w_memw = 1'b1;
      end
      S_EXECR: begin
        ALUCtrl = w_alu_dp;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01; ALUCtrl = w_alu_dp;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_regw = !w_nowrite; w_pcw = w_rd15 & !w_nowrite;
      end
      S_BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; w_pcw = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign PCWrite  = w_pcw  & ~Reset;
  assign MemWrite = w_memw & ~Reset;
  assign RegWrite = w_regw & ~Reset;
  assign IRWrite  = w_irw  & ~Reset;
  assign ImmSrc   = w_op;
  assign RegSrc   = {w_op == 2'b01, w_op == 2'b10};
  assign State    = r_state;
  assign Flags    = r_flags;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected state/strobes/muxes/flags queued per instruction.
module tb_multicycle_controller;
  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ALUCtrl, ImmSrc, RegSrc;
  logic [3:0]  State, Flags;

  multicycle_controller #(.FLAGS_RESET(4'b0000)) dut (
    .clk(clk), .Reset(Reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUCtrl(ALUCtrl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State), .Flags(Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic [3:0] strb;
    logic [7:0] aux;
    logic [3:0] fl;
  } exp_t;

  exp_t       q[$];
  logic [3:0] exp_fl;
  int         n_chk  = 0;
  int         n_pass = 0;

`ifdef CMP_TST_NOWRITE_EN
  localparam logic [1:0] CMP_ALU = 2'b01, TST_ALU = 2'b10;
  localparam logic [3:0] CT_WB   = 4'b0000, TST_FL = 4'b0101;
`else
  localparam logic [1:0] CMP_ALU = 2'b00, TST_ALU = 2'b00;
  localparam logic [3:0] CT_WB   = 4'b0010, TST_FL = 4'b0110;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUCtrl} per state from the control table
  function automatic logic [7:0] aux_of(input logic [3:0] st, input logic [1:0] alu);
    case (st)
      4'd0, 4'd1: return {1'b0, 2'b10, 1'b1, 2'b10, 2'b00};
      4'd2:       return {1'b0, 2'b00, 1'b0, 2'b01, 2'b00};
      4'd3, 4'd5: return {1'b1, 2'b00, 1'b0, 2'b00, 2'b00};
      4'd4:       return {1'b0, 2'b01, 1'b0, 2'b00, 2'b00};
      4'd6:       return {1'b0, 2'b00, 1'b0, 2'b00, alu};
      4'd7:       return {1'b0, 2'b00, 1'b0, 2'b01, alu};
      4'd9:       return {1'b0, 2'b10, 1'b0, 2'b01, 2'b00};
      default:    return 8'h00;
    endcase
  endfunction

  task automatic step(input logic [3:0] st, input logic [3:0] strb, input logic [1:0] alu);
    exp_t e;
    e.st = st; e.strb = strb; e.aux = aux_of(st, alu); e.fl = exp_fl;
    q.push_back(e);
  endtask

  task automatic run(input logic [31:0] ins, input logic [3:0] af);
    Instr = ins;
    ALUFlags = af;
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      #1;
      check("state", 32'(State), 32'(e.st));
      check("strobes", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'(e.strb));
      check("muxes", 32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUCtrl}), 32'(e.aux));
      check("flags", 32'(Flags), 32'(e.fl));
      check("imm_regsrc", 32'({ImmSrc, RegSrc}),
            32'({Instr[27:26], Instr[27:26] == 2'b01, Instr[27:26] == 2'b10}));
      @(negedge clk);
    end
  endtask

  initial begin
    Reset = 1'b1; Instr = '0; ALUFlags = '0; exp_fl = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_state", 32'(State), 32'd0);
    check("rst_flags", 32'(Flags), 32'd0);
    check("rst_strobes", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
    Reset = 1'b0;

    run(32'hE5912000, 4'h0); // LDR R2,[R1]
    step(0, 4'h9, 0); step(1, 0, 0); step(2, 0, 0); step(3, 0, 0); step(4, 4'h2, 0); drain();
    run(32'hE5812000, 4'h0); // STR R2,[R1]
    step(0, 4'h9, 0); step(1, 0, 0); step(2, 0, 0); step(5, 4'h4, 0); drain();
    run(32'h0A000002, 4'h0); // BEQ, Z=0
    step(0, 4'h9, 0); step(1, 0, 0); drain();
    run(32'hE2511001, 4'h6); // SUBS R1,R1,#1
    step(0, 4'h9, 0); step(1, 0, 0); step(7, 0, 2'b01); exp_fl = 4'b0110; step(8, 4'h2, 0); drain();
    run(32'h0A000002, 4'h0); // BEQ, Z=1
    step(0, 4'h9, 0); step(1, 0, 0); step(9, 4'h8, 0); drain();
    run(32'hE0921003, 4'hB); // ADDS R1,R2,R3
    step(0, 4'h9, 0); step(1, 0, 0); step(6, 0, 2'b00); exp_fl = 4'b1011; step(8, 4'h2, 0); drain();
    run(32'hE0121003, 4'h4); // ANDS: C,V kept
    step(0, 4'h9, 0); step(1, 0, 0); step(6, 0, 2'b10); exp_fl = 4'b0111; step(8, 4'h2, 0); drain();
    run(32'h1A000002, 4'h0); // BNE, Z=1 -> skip
    step(0, 4'h9, 0); step(1, 0, 0); drain();
    run(32'hBA000002, 4'h0); // BLT, N!=V -> taken
    step(0, 4'h9, 0); step(1, 0, 0); step(9, 4'h8, 0); drain();
    run(32'hE180F002, 4'hF); // ORR PC,R0,R2, S=0
    step(0, 4'h9, 0); step(1, 0, 0); step(6, 0, 2'b11); step(8, 4'hA, 0); drain();
    run(32'hF0000000, 4'h0); // cond 1111 never
    step(0, 4'h9, 0); step(1, 0, 0); drain();
    run(32'hEC000000, 4'h0); // Op=11 undefined
    step(0, 4'h9, 0); step(1, 0, 0); drain();
    run(32'hE591F000, 4'h0); // LDR PC,[R1]
    step(0, 4'h9, 0); step(1, 0, 0); step(2, 0, 0); step(3, 0, 0); step(4, 4'hA, 0); drain();
    run(32'hE3510005, 4'h9); // CMP R1,#5
    step(0, 4'h9, 0); step(1, 0, 0); step(7, 0, CMP_ALU); exp_fl = 4'b1001; step(8, CT_WB, 0); drain();
    run(32'hE3110005, 4'h6); // TST R1,#5
    step(0, 4'h9, 0); step(1, 0, 0); step(7, 0, TST_ALU); exp_fl = TST_FL; step(8, CT_WB, 0); drain();

    // Reset held two cycles in the middle of a load
    run(32'hE5912000, 4'h0);
    step(0, 4'h9, 0); step(1, 0, 0); step(2, 0, 0); drain();
    #1 check("mid_state", 32'(State), 32'd3);
    Reset = 1'b1;
    @(negedge clk); #1;
    check("rst1_state", 32'(State), 32'd0);
    check("rst1_strobes", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
    check("rst1_flags", 32'(Flags), 32'd0);
    @(negedge clk); #1;
    check("rst2_state", 32'(State), 32'd0);
    check("rst2_strobes", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
    Reset = 1'b0;
    exp_fl = 4'b0000;
    run(32'hE5812000, 4'h0);
    step(0, 4'h9, 0); step(1, 0, 0); step(2, 0, 0); step(5, 4'h4, 0); drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
